// File: rtl/program_loader.sv
// Boot loader: writes a length-prefixed word stream into instruction memory, then releases
// full_machine from reset, counts its run cycles and re-asserts reset on an exception.
module program_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              except,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              machine_reset,
  output logic              running,
  output logic              halted,
  output logic              error,
  output logic [31:0]       run_cycles
);

  localparam int unsigned      Depth    = 2 ** ADDR_W;
  localparam int unsigned      HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0]  DepthN   = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0]  OneN     = (ADDR_W + 1)'(1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StHeader, StLoad, StRelease, StRun, StHalt, StError
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, k_q;
  logic [HoldW-1:0]  hold_q;
  logic [31:0]       run_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic [ADDR_W:0] hdr_n;
  logic            hdr_xfer, load_xfer, word_is_last, frame_ok, load_wr, hold_done, clr_run;

  // Header bits above ADDR_W are ignored; one extra bit lets N reach DEPTH.
  assign hdr_n        = in_data[ADDR_W:0];
  assign hdr_xfer     = (state_q == StHeader) && in_valid;
  assign load_xfer    = (state_q == StLoad) && in_valid;
  assign word_is_last = (k_q == n_q - OneN);
  assign frame_ok     = (in_last == word_is_last);
  assign load_wr      = load_xfer && frame_ok;
  assign hold_done    = (hold_q == HoldLast);
  assign clr_run      = start && (state_q inside {StRun, StHalt, StError});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StHeader;
      StHeader: begin
        if (in_valid) begin
          if (hdr_n > DepthN)    state_d = StError;
          else if (hdr_n == '0)  state_d = in_last ? StRelease : StError;
          else if (in_last)      state_d = StError;
          else                   state_d = StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (!frame_ok)    state_d = StError;
          else if (in_last) state_d = StRelease;
        end
      end
      StRelease: if (hold_done) state_d = StRun;
      // start takes priority over a simultaneous exception.
      StRun: begin
        if (start)       state_d = StHeader;
        else if (except) state_d = StHalt;
      end
      StHalt, StError: if (start) state_d = StHeader;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    machine_reset = 1'b1;
    running       = 1'b0;
    halted        = 1'b0;
    error         = 1'b0;
    unique case (state_q)
      StHeader, StLoad: in_ready = 1'b1;
      StRun: begin
        machine_reset = 1'b0;
        running       = 1'b1;
      end
      StHalt:  halted = 1'b1;
      StError: error  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q       <= '0;
      k_q       <= '0;
      hold_q    <= '0;
      run_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (hdr_xfer) begin
        n_q <= hdr_n;
        k_q <= '0;
      end else if (load_wr) begin
        k_q <= k_q + OneN;
      end
      hold_q <= (state_q == StRelease) ? hold_q + HoldW'(1) : '0;
      if (clr_run) begin
        run_q <= '0;
      end else if ((state_q == StRun) && (run_q != '1)) begin
        run_q <= run_q + 32'd1;
      end
      wr_en_q <= load_wr;
      if (load_wr) begin
        wr_addr_q <= k_q[ADDR_W-1:0];
        wr_data_q <= in_data;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: a framing model predicts the write stream, which a
// negedge monitor checks against wr_en/wr_addr/wr_data; status and timing are checked inline.
module tb_program_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned HOLD  = 2;
  localparam int          DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          except = 1'b0;
  logic          in_ready, wr_en, machine_reset, running, halted, error;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data, run_cycles;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit poke_start = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            due;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  program_loader #(.ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .except(except), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .machine_reset(machine_reset),
    .running(running), .halted(halted), .error(error), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Scoreboard monitor: every write must match the oldest expected one, in the right cycle.
  always @(negedge clk) begin
    if (reset && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr,
                 wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", wr_data, mon_e.data);
        check("wr_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Framing rules: header length valid and consistent with its last flag, then in_last
  // exactly on word N. Reports how many words are written and whether the packet fails.
  function automatic void model(input int n, input bit hl, input bit lf[$],
                                output bit hdr_err, output bit err, output int nwr);
    hdr_err = (n > DEPTH) || ((n == 0) != hl);
    err     = hdr_err;
    nwr     = 0;
    if (!hdr_err) begin
      foreach (lf[i]) begin
        if (lf[i] != (i == n - 1)) begin
          err = 1'b1;
          return;
        end
        nwr++;
      end
    end
  endfunction

  // Called and returns #1 after a rising edge.
  task automatic send(input logic [31:0] d, input logic last, input int gap, input bit wr,
                      input int a);
    int  budget;
    wr_t w;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      start    = poke_start;
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    budget   = 50;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (wr) begin
      w.addr = AW'(a);
      w.data = d;
      w.due  = cyc;
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b0);
    check1({tag, "_machine_reset"}, machine_reset, 1'b1);
    check1({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check1({tag, "_running"}, running, 1'b0);
    check1({tag, "_halted"}, halted, 1'b0);
    check1({tag, "_error"}, error, 1'b0);
    check({tag, "_run_cycles"}, run_cycles, 32'd0);
  endtask

  // Streams header + words; r > 0 raises except on the r-th RUN cycle.
  task automatic run_packet(input logic [31:0] hdr, input bit hl, input bit lf[$],
                            input logic [31:0] dq[$], input int gap, input int r);
    int n, nwr;
    bit hdr_err, err;
    n = int'(hdr[AW:0]);
    model(n, hl, lf, hdr_err, err, nwr);
    send(hdr, hl, (gap < 0) ? int'($urandom_range(0, 2)) : gap, 1'b0, 0);
    if (!hdr_err) begin
      foreach (lf[i]) begin
        send(dq[i], lf[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap, i < nwr, i);
        if (i >= nwr) break;
      end
    end
    if (err) begin
      @(negedge clk);
      check1("err_flag", error, 1'b1);
      check1("err_in_ready", in_ready, 1'b0);
      check1("err_machine_reset", machine_reset, 1'b1);
      @(posedge clk);
      #1;
      return;
    end
    for (int i = 1; i <= HOLD + 1; i++) begin
      @(negedge clk);
      check1("release_machine_reset", machine_reset, i <= HOLD);
    end
    check1("run_running", running, 1'b1);
    check("run_start_count", run_cycles, 32'd0);
    if (r > 0) begin
      if (r > 1) begin
        repeat (r - 1) @(posedge clk);
        #1;
      end
      except = 1'b1;
      @(posedge clk);
      #1;
      except = 1'b0;
      @(negedge clk);
      check1("halt_halted", halted, 1'b1);
      check1("halt_running", running, 1'b0);
      check1("halt_machine_reset", machine_reset, 1'b1);
      check("halt_run_cycles", run_cycles, 32'(r));
      repeat (3) @(posedge clk);
      #1;
      check("halt_frozen", run_cycles, 32'(r));
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          lf[$];
    logic [31:0] dq[$];
    int          n, kind;
    bit          hl;

    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("por");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");
    @(posedge clk);
    #1;

    // Normal load of three words, exception on the 10th RUN cycle.
    pulse_start();
    lf = '{1'b0, 1'b0, 1'b1};
    dq = '{32'hA, 32'hB, 32'hC};
    run_packet(32'd3, 1'b0, lf, dq, 0, 10);

    // Restart from HALT with an empty image.
    pulse_start();
    check("restart_cleared", run_cycles, 32'd0);
    lf.delete();
    dq.delete();
    run_packet(32'd0, 1'b1, lf, dq, 0, 3);

    // Gapped four-word load; start pulses during the gaps must be ignored.
    pulse_start();
    lf = '{1'b0, 1'b0, 1'b0, 1'b1};
    dq = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    poke_start = 1'b1;
    run_packet(32'd4, 1'b0, lf, dq, 1, 1);
    poke_start = 1'b0;

    // Early in_last on word 1 of 2.
    pulse_start();
    lf = '{1'b1};
    dq = '{32'hDEAD_BEEF};
    run_packet(32'd2, 1'b0, lf, dq, 0, 0);

    // Oversized header DEPTH+1 (upper header bits are junk).
    pulse_start();
    lf.delete();
    dq.delete();
    run_packet(32'hABC0_0000 | 32'(DEPTH + 1), 1'b0, lf, dq, 0, 0);

    // Full-depth image.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      lf.push_back(i == DEPTH - 1);
      dq.push_back($urandom());
    end
    run_packet(32'(DEPTH), 1'b0, lf, dq, 0, 2);

    // start and except together in RUN: start wins.
    pulse_start();
    lf.delete();
    dq.delete();
    run_packet(32'd0, 1'b1, lf, dq, 0, 0);
    start  = 1'b1;
    except = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    except = 1'b0;
    check1("start_wins_in_ready", in_ready, 1'b1);
    check1("start_wins_halted", halted, 1'b0);
    check("start_wins_run_cycles", run_cycles, 32'd0);

    // Reset after the 2nd of 5 words; pending write is dropped.
    send(32'd5, 1'b0, 0, 1'b0, 0);
    send(32'h5555_0000, 1'b0, 0, 1'b1, 0);
    send(32'h5555_0001, 1'b0, 0, 1'b1, 1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("midload");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");
    @(posedge clk);
    #1;
    pulse_start();
    lf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dq = '{32'h6666_0000, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003, 32'h6666_0004};
    run_packet(32'd5, 1'b0, lf, dq, 0, 2);

    // Randomised packets, including framing faults.
    for (int t = 0; t < 30; t++) begin
      lf.delete();
      dq.delete();
      kind = int'($urandom_range(0, 5));
      n    = int'($urandom_range(0, DEPTH));
      hl   = (n == 0);
      for (int i = 0; i < n; i++) begin
        lf.push_back(i == n - 1);
        dq.push_back($urandom());
      end
      if (kind == 3 && n >= 2) lf[$urandom_range(0, n - 2)] = 1'b1;
      if (kind == 4 && n >= 1) lf[n - 1] = 1'b0;
      if (kind == 5) begin
        case ($urandom_range(0, 2))
          0: begin
            n  = int'($urandom_range(DEPTH + 1, 2 * DEPTH - 1));
            hl = 1'($urandom_range(0, 1));
          end
          1: begin
            n  = 0;
            hl = 1'b0;
          end
          default: begin
            if (n == 0) n = 1;
            hl = 1'b1;
          end
        endcase
      end
      pulse_start();
      run_packet(($urandom() << (AW + 1)) | 32'(n), hl, lf, dq, -1,
                 int'($urandom_range(1, 15)));
    end

    @(negedge clk);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time front end that sits directly upstream of `full_machine`. It accepts a length-prefixed program as a stream of 32-bit words, writes them into the instruction memory through a write port, and holds the machine in reset until the image is complete. It then releases the machine, counts its run cycles, and re-asserts the machine reset when the machine raises `except`. Benches and the top level use it instead of preloading instruction memory from a file.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width. Depth is `DEPTH = 2**ADDR_W`.
- `HOLD_CYCLES`, 2: cycles that `machine_reset` stays high after the final write is accepted. Legal range is ≥1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  stream word valid.
- `in_data`  in  32  stream word: the header word first, then the program words.
- `in_last`  in  1  marks the final word of the packet.
- `in_ready`  out  1  loader can accept a word. A word transfers on a cycle where `in_valid & in_ready` is high.
- `except`  in  1  exception output of `full_machine`.
- `wr_en`  out  1  instruction-memory write strobe.
- `wr_addr`  out  ADDR_W  instruction-memory word address.
- `wr_data`  out  32  instruction-memory write data.
- `machine_reset`  out  1  active-high reset to `full_machine`.
- `running`, `halted`, `error`  out  1 each  status flags.
- `run_cycles`  out  32  count of cycles spent in RUN.

## Operation
- States: IDLE, HEADER, LOAD, RELEASE, RUN, HALT, ERROR.
- `in_ready` is 1 only in HEADER and LOAD.
- `machine_reset` is 0 only in RUN.
- `running` = (state == RUN), `halted` = (state == HALT), `error` = (state == ERROR).

Transitions:
- IDLE: on `start` go to HEADER.
- HEADER: on a transfer, N = `in_data[ADDR_W:0]`; bits `in_data[31:ADDR_W+1]` are ignored.
  - N > DEPTH → ERROR.
  - N == 0 with `in_last` = 1 → RELEASE.
  - N == 0 with `in_last` = 0 → ERROR.
  - N ≥ 1 with `in_last` = 1 → ERROR.
  - Otherwise clear the word counter k and go to LOAD.
- LOAD: on each transfer, write the word to address k, then k ← k+1.
  - `in_last` must be high exactly on word N (k == N−1); it must be low on every earlier word.
  - Any mismatch → ERROR. The mismatching word is not written.
  - After word N is accepted → RELEASE.
- RELEASE: a hold counter runs HOLD_CYCLES cycles, then the block goes to RUN.
- RUN: `run_cycles` increments every cycle and saturates at 0xFFFFFFFF. When `except` = 1 → HALT.
- HALT: `run_cycles` is frozen.
- From RUN, HALT or ERROR, `start` goes to HEADER and clears `run_cycles` to 0.
- `start` is ignored in HEADER, LOAD and RELEASE.
- No transfers occur outside HEADER and LOAD.

Write rules:
- The header word is never written.
- Writes are registered. `wr_en` pulses for one cycle per program word, and `wr_addr` increments from 0.
- `wr_addr` and `wr_data` hold their last values when `wr_en` = 0.

## Timing
- Reset values:
  - state = IDLE, `machine_reset` = 1, `in_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `running` = `halted` = `error` = 0, `run_cycles` = 0.
  - Internal counters k and hold counter = 0.
- Assertion of `reset` at any time, including mid-load or mid-run, takes effect immediately:
  - all outputs return to their reset values, including `machine_reset` = 1;
  - a pending registered write is dropped.
- Write latency: a transfer in cycle t produces `wr_en` = 1 in cycle t+1.
- Back-to-back transfers produce one write per cycle.
- Release latency: word N is accepted in cycle t.
  - Cycles t+1 .. t+HOLD_CYCLES are RELEASE.
  - `machine_reset` first reads 0 in cycle t+1+HOLD_CYCLES.
  - Because HOLD_CYCLES ≥ 1, the last write always lands before the machine leaves reset.
- `except` sampled high in RUN cycle u:
  - `machine_reset` = 1 from u+1;
  - `run_cycles` holds the value it had after cycle u's increment.
- `in_valid` may be low between words; the loader waits indefinitely without timeout.
- When `start` and `except` are both high in RUN, `start` wins and the next state is HEADER.

## Test plan
- Normal load, HOLD_CYCLES = 2:
  - Stimulus: header 3, then words 0xA, 0xB, 0xC back-to-back with `in_last` on 0xC.
  - Required: writes (0,0xA), (1,0xB), (2,0xC) on consecutive cycles.
  - Required: `machine_reset` falls 3 cycles after 0xC is accepted.
- Gapped stream: `in_valid` toggles every other cycle for a 4-word load. Required: 4 writes at addresses 0..3, same data order, no extra `wr_en` pulses.
- Framing errors:
  - Header 2 with `in_last` on word 1 → ERROR, only 0 writes.
  - Header with `in_data[ADDR_W:0]` = DEPTH+1 → ERROR.
  - In both cases `machine_reset` stays 1 and `in_ready` = 0.
- Exception halt:
  - Stimulus: load, then raise `except` on the 10th RUN cycle.
  - Required: `halted` = 1, `run_cycles` = 10, `machine_reset` = 1.
  - Then `start` plus header 0 with `in_last` → `run_cycles` cleared, RUN re-entered.
- Reset mid-load:
  - Stimulus: drive `reset` low for 1 cycle after the 2nd of 5 words.
  - Required: all outputs return to reset values immediately and the state is IDLE.
  - Required: a following full load writes again from address 0.
